store_buffer: RTL and testbench

Write-side counterpart of the immediate/load extension path. It takes 32-bit store requests (sb/sh/sw) from the CPU datapath and narrows each to a word-aligned address, replicated write data and a 4-bit byte-enable. Entries are queued in a small FIFO and drained to data memory over a req/ack handshake. It sits between the MEM-stage store logic and the data memory port.

---
 rtl/store_buffer.sv | 186 ++++++++++++++++++
 tb/tb_store_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// ----------------------------------------------------------------------------
// store_buffer
//
// Purpose:
//   Accepts CPU store requests (sb/sh/sw), narrows each one to a word-aligned
//   address, lane-replicated write data and a 4-bit byte enable, then queues
//   it in a small FIFO. The FIFO drains to data memory over a req/ack
//   handshake. Misaligned stores, and stores of the reserved size, complete
//   their handshake but are not queued. Such a store raises err_misalign for
//   one cycle.
//
// Optional feature (compile-time macro STORE_MERGE_EN):
//   When the macro is defined, an aligned store to the same word as the tail
//   entry is merged into that entry instead of allocating a new one. The merge
//   only happens while the tail is not also the head (count >= 2). The new
//   bytes overwrite the old ones, and the byte enables are OR-ed together.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   st_valid/st_ready          store request handshake (st_ready = !full)
//   st_addr, st_data, st_size  byte address, right-aligned data, 00/01/10 size
//   mem_req/mem_ack            head entry valid / memory accepted head
//   mem_addr, mem_wdata, mem_be  head entry (word address, data, byte enables)
//   err_misalign               one-cycle pulse after a rejected store
//   count, empty               occupancy and empty flag
// ----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [1:0]       st_size,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             err_misalign,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Entry storage. The read is asynchronous from the head pointer, so the
    // head fields are visible in the cycle right after the push.
    logic [29:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [3:0]  be_mem   [DEPTH];

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;
    logic             err_reg,    err_next;

    logic        full;
    logic        accept;
    logic        push;
    logic        pop;
    logic        merge;
    logic        misalign;
    logic [31:0] new_wdata;
    logic [3:0]  new_be;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign st_ready = !full;
    assign empty    = (count_reg == '0);
    assign mem_req  = !empty;
    assign count    = count_reg;

    assign err_misalign = err_reg;
    assign mem_addr     = {addr_mem[rd_ptr_reg], 2'b00};
    assign mem_wdata    = data_mem[rd_ptr_reg];
    assign mem_be       = be_mem[rd_ptr_reg];

    // Narrow the store: replicate the data across every lane it could occupy,
    // then select the real lanes with the byte enable.
    always_comb begin
        new_wdata = st_data;
        new_be    = 4'b0000;
        misalign  = 1'b0;
        case (st_size)
            2'b00: begin
                new_wdata = {4{st_data[7:0]}};
                new_be    = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                misalign  = st_addr[0];
                new_wdata = {2{st_data[15:0]}};
                new_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                misalign  = (st_addr[1:0] != 2'b00);
                new_wdata = st_data;
                new_be    = 4'b1111;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

    // A push while full never happens: st_ready is low when full, even if
    // the head is popped in the same cycle.
    assign accept = st_valid && !full;
    assign pop    = mem_req && mem_ack;

`ifdef STORE_MERGE_EN
    logic [AW-1:0] tail_ptr;
    logic [31:0]   merged_wdata;

    assign tail_ptr = wr_ptr_reg - 1'b1;

    // The rule count >= 2 keeps the head entry frozen while memory sees it.
    // When the head is popped in the same cycle, the tail is still a
    // different entry.
    assign merge = accept && !misalign && (count_reg >= CNT_W'(2))
                   && (addr_mem[tail_ptr] == st_addr[31:2]);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge_lane
            assign merged_wdata[8*gi +: 8] = new_be[gi] ? new_wdata[8*gi +: 8]
                                                        : data_mem[tail_ptr][8*gi +: 8];
        end
    endgenerate
`else
    assign merge = 1'b0;
`endif

    assign push = accept && !misalign && !merge;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        err_next    = accept && misalign;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
        end
    end

    // The storage has no reset. After a reset the pointers and count make
    // any stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= st_addr[31:2];
            data_mem[wr_ptr_reg] <= new_wdata;
            be_mem[wr_ptr_reg]   <= new_be;
        end
`ifdef STORE_MERGE_EN
        if (merge) begin
            data_mem[tail_ptr] <= merged_wdata;
            be_mem[tail_ptr]   <= be_mem[tail_ptr] | new_be;
        end
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// ----------------------------------------------------------------------------
// tb_store_buffer
//
// Purpose:
//   Self-checking bench for store_buffer. A queue-based reference model holds
//   the expected entries as {word address, data, byte enable}. Directed steps
//   and randomized cycles both update the model. After every clock edge, all
//   outputs are compared against the model. Directed steps also check the
//   worked examples against literal values, to pin down the model itself.
//   Build with +define+STORE_MERGE_EN to check the merging variant.
// ----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef STORE_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             st_valid = 1'b0;
    logic             st_ready;
    logic [31:0]      st_addr = '0;
    logic [31:0]      st_data = '0;
    logic [1:0]       st_size = '0;
    logic             mem_req;
    logic             mem_ack = 1'b0;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             err_misalign;
    logic [CNT_W-1:0] count;
    logic             empty;

    store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_size      (st_size),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .err_misalign (err_misalign),
        .count        (count),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] wa;
        logic [31:0] wd;
        logic [3:0]  be;
    } entry_t;

    entry_t q[$];
    bit     err_exp = 1'b0;
    int     vectors = 0;
    int     miscompares = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference behaviour for one clock edge with the given inputs.
    function automatic void model_edge(bit v, logic [31:0] a, logic [31:0] d,
                                       logic [1:0] sz, bit ack, bit rst);
        bit     ready, acc, do_pop, bad;
        int     lo;
        entry_t e;
        if (rst) begin
            q.delete();
            err_exp = 1'b0;
            $display("[%0t] reset", $time);
            return;
        end
        ready  = (q.size() < DEPTH);
        acc    = v && ready;
        do_pop = (q.size() > 0) && ack;
        lo     = int'(a[1:0]);
        // A store is legal when it is naturally aligned for its size.
        case (sz)
            2'd0:    bad = 1'b0;
            2'd1:    bad = (lo % 2) != 0;
            2'd2:    bad = (lo != 0);
            default: bad = 1'b1;
        endcase
        err_exp = acc && bad;
        e.wa = a[31:2];
        e.be = '0;
        e.wd = '0;
        for (int b = 0; b < 4; b++) begin
            if (sz == 2'd0) begin
                e.wd[8*b +: 8] = d[7:0];
                e.be[b] = (b == lo);
            end else if (sz == 2'd1) begin
                e.wd[8*b +: 8] = (b % 2 == 0) ? d[7:0] : d[15:8];
                e.be[b] = (b / 2 == lo / 2);
            end else begin
                e.wd[8*b +: 8] = d[8*b +: 8];
                e.be[b] = 1'b1;
            end
        end
        if (acc && bad) begin
            $display("[%0t] reject addr=%h size=%0d", $time, a, sz);
        end else if (acc) begin
            if (MERGE && q.size() >= 2 && q[$].wa == e.wa) begin
                for (int b = 0; b < 4; b++) begin
                    if (e.be[b]) q[$].wd[8*b +: 8] = e.wd[8*b +: 8];
                end
                q[$].be = q[$].be | e.be;
                $display("[%0t] merge  addr=%h be=%b", $time, a, e.be);
            end else begin
                $display("[%0t] push   addr=%h wdata=%h be=%b", $time, a, e.wd, e.be);
                q.push_back(e);
            end
        end
        if (do_pop) begin
            $display("[%0t] pop    addr=%h wdata=%h be=%b", $time,
                     {q[0].wa, 2'b00}, q[0].wd, q[0].be);
            q.pop_front();
        end
    endfunction

    function automatic void compare();
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
        chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
        chk("err_misalign", 32'(err_misalign), 32'(err_exp));
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, {q[0].wa, 2'b00});
            chk("mem_wdata", mem_wdata, q[0].wd);
            chk("mem_be", 32'(mem_be), 32'(q[0].be));
        end
    endfunction

    // Called just after a falling edge. It drives the inputs, advances the
    // model across the next rising edge, and compares at the following
    // falling edge.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input bit ack, input bit rst);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        mem_ack  = ack;
        reset    = rst;
        model_edge(v, a, d, sz, ack, rst);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input bit ack);
        step(1'b0, 32'h0, 32'h0, 2'd0, ack, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        chk("lit_reset_empty", 32'(empty), 32'd1);
        chk("lit_reset_ready", 32'(st_ready), 32'd1);
        chk("lit_reset_req", 32'(mem_req), 32'd0);

        // A word store becomes visible one edge after acceptance.
        step(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
        chk("lit_sw_req", 32'(mem_req), 32'd1);
        chk("lit_sw_addr", mem_addr, 32'h100);
        chk("lit_sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("lit_sw_be", 32'(mem_be), 32'hF);
        idle(1'b1);
        chk("lit_sw_drained", 32'(empty), 32'd1);

        // Byte and halfword narrowing.
        step(1'b1, 32'h203, 32'h000000A5, 2'd0, 1'b0, 1'b0);
        chk("lit_sb_addr", mem_addr, 32'h200);
        chk("lit_sb_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("lit_sb_be", 32'(mem_be), 32'h8);
        step(1'b1, 32'h202, 32'h00001234, 2'd1, 1'b1, 1'b0);
        chk("lit_sh_wdata", mem_wdata, 32'h12341234);
        chk("lit_sh_be", 32'(mem_be), 32'hC);
        idle(1'b1);

        // Misaligned stores are rejected with a one-cycle error pulse.
        step(1'b1, 32'h301, 32'h1, 2'd1, 1'b0, 1'b0);
        chk("lit_mis_sh_err", 32'(err_misalign), 32'd1);
        step(1'b1, 32'h302, 32'h2, 2'd2, 1'b0, 1'b0);
        chk("lit_mis_sw_err", 32'(err_misalign), 32'd1);
        chk("lit_mis_count", 32'(count), 32'd0);
        idle(1'b0);
        chk("lit_mis_err_clear", 32'(err_misalign), 32'd0);

        // Fill the buffer, stall a fifth store, then release it, crossing the
        // pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h500 + 32'(4*i), 32'h5000 + 32'(i), 2'd2, 1'b0, 1'b0);
        end
        chk("lit_full_count", 32'(count), 32'd4);
        chk("lit_full_ready", 32'(st_ready), 32'd0);
        step(1'b1, 32'h510, 32'h5004, 2'd2, 1'b0, 1'b0);
        chk("lit_stall_count", 32'(count), 32'd4);
        step(1'b1, 32'h510, 32'h5004, 2'd2, 1'b1, 1'b0);
        chk("lit_pop_full_count", 32'(count), 32'd3);
        step(1'b1, 32'h510, 32'h5004, 2'd2, 1'b0, 1'b0);
        chk("lit_refill_count", 32'(count), 32'd4);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("lit_drain_order", mem_addr, 32'h500 + 32'(4*i));
            idle(1'b1);
        end

        // Simultaneous push and pop at count 2, then reset mid-drain.
        step(1'b1, 32'h700, 32'h1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 32'h710, 32'h2, 2'd2, 1'b0, 1'b0);
        step(1'b1, 32'h720, 32'h3, 2'd2, 1'b1, 1'b0);
        chk("lit_pushpop_count", 32'(count), 32'd2);
        step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        chk("lit_rst_mid_req", 32'(mem_req), 32'd0);
        chk("lit_rst_mid_count", 32'(count), 32'd0);

        // Same-word stores behind the head.
        step(1'b1, 32'h400, 32'h11111111, 2'd2, 1'b0, 1'b0);
        step(1'b1, 32'h404, 32'h000000AA, 2'd0, 1'b0, 1'b0);
        step(1'b1, 32'h405, 32'h000000BB, 2'd0, 1'b0, 1'b0);
`ifdef STORE_MERGE_EN
        chk("lit_merge_count", 32'(count), 32'd2);
        idle(1'b1);
        chk("lit_merge_be", 32'(mem_be), 32'h3);
        chk("lit_merge_wdata", 32'(mem_wdata[15:0]), 32'hBBAA);
`else
        chk("lit_nomerge_count", 32'(count), 32'd3);
        idle(1'b1);
        chk("lit_nomerge_be", 32'(mem_be), 32'h1);
        chk("lit_nomerge_wdata", mem_wdata, 32'hAAAAAAAA);
`endif
        for (int i = 0; i < DEPTH; i++) idle(1'b1);

        // Randomized traffic. The addresses are clustered so that same-word
        // stores, merges and full stalls all occur often.
        for (int n = 0; n < 1500; n++) begin
            bit          v, ack, rst;
            logic [31:0] a;
            logic [1:0]  sz;
            v   = ($urandom_range(0, 99) < 60);
            ack = ($urandom_range(0, 99) < 45);
            rst = ($urandom_range(0, 199) == 0);
            a   = 32'h600 + 32'($urandom_range(0, 2) * 4) + 32'($urandom_range(0, 3));
            sz  = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 2)) : 2'd3;
            step(v, a, $urandom, sz, ack, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
